// File: rtl/mm_defs.sv
// mm_defs: shared state encoding and bus-width defaults for the main-memory access path.
package mm_defs;
    localparam int MM_DATAWIDTH_BUS  = 32;
    localparam int MM_MEM_ADDR_WIDTH = 10;
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_ACKST, ST_RECOV} mm_state_t;
endpackage

// File: rtl/mm_memory_array.sv
// mm_memory_array: single-port word RAM with write enable and registered read data.
module mm_memory_array
    import mm_defs::*;
#(
    parameter int DW = MM_DATAWIDTH_BUS,
    parameter int AW = MM_MEM_ADDR_WIDTH
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) mem_q[addr_i] <= wdata_i;
        if (en_i && !we_i) rdata_q <= mem_q[addr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/mm_access_controller.sv
// mm_access_controller: wait-stated main-memory access with registered data, ACK and ERR
// back to the CSAI; requests are ignored while busy and for a recovery window after ACK.
module mm_access_controller
    import mm_defs::*;
#(
    parameter int DATAWIDTH_BUS   = MM_DATAWIDTH_BUS,
    parameter int MEM_ADDR_WIDTH  = MM_MEM_ADDR_WIDTH,
    parameter int WAIT_STATES     = 2,
    parameter int RECOVERY_CYCLES = 1
) (
    input  logic                     MM_Access_CLOCK_50,
    input  logic                     MM_Access_RESET_InLow,
    input  logic                     MM_Access_RD,
    input  logic                     MM_Access_WR,
    input  logic [DATAWIDTH_BUS-1:0] MM_Access_Address_InBUS,
    input  logic [DATAWIDTH_BUS-1:0] MM_Access_Data_InBUS,
    output logic [DATAWIDTH_BUS-1:0] MM_Access_Data_OutBUS,
    output logic                     MM_Access_ACK,
    output logic                     MM_Access_ERR,
    output logic                     MM_Access_Busy
);
    localparam int CNT_MAX = WAIT_STATES > RECOVERY_CYCLES ? WAIT_STATES : RECOVERY_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1) + 1;
    localparam logic [CW-1:0] WAIT_LAST  = CW'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
    localparam logic [CW-1:0] RECOV_LAST = CW'(RECOVERY_CYCLES);

    mm_state_t                 state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      wr_q, bad_q, lat, bad;
    logic [MEM_ADDR_WIDTH-1:0] idx_q;
    logic [DATAWIDTH_BUS-1:0]  wdata_q, dout_q, rdata;
    logic                      ack_q, err_q, busy_q;

    assign bad = (MM_Access_RD & MM_Access_WR) | (|MM_Access_Address_InBUS[1:0])
               | (|MM_Access_Address_InBUS[DATAWIDTH_BUS-1:MEM_ADDR_WIDTH+2]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat     = 1'b0;
        case (state_q)
            ST_IDLE: if (MM_Access_RD | MM_Access_WR) begin
                lat     = 1'b1;
                cnt_d   = '0;
                state_d = bad ? ST_ACKST : (WAIT_STATES == 0 ? ST_ACCESS : ST_WAIT);
            end
            ST_WAIT: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == WAIT_LAST ? ST_ACCESS : ST_WAIT;
            end
            ST_ACCESS: state_d = ST_ACKST;
            ST_ACKST: begin
                cnt_d   = '0;
                state_d = ST_RECOV;
            end
            ST_RECOV: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == RECOV_LAST ? ST_IDLE : ST_RECOV;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ACK is registered off ACKST so it lines up with the read data register.
    always_ff @(posedge MM_Access_CLOCK_50 or negedge MM_Access_RESET_InLow) begin
        if (!MM_Access_RESET_InLow) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            bad_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (lat) begin
                wr_q    <= MM_Access_WR;
                bad_q   <= bad;
                idx_q   <= MM_Access_Address_InBUS[MEM_ADDR_WIDTH+1:2];
                wdata_q <= MM_Access_Data_InBUS;
            end
            if (state_q == ST_ACKST && !bad_q && !wr_q) dout_q <= rdata;
            ack_q  <= state_q == ST_ACKST;
            err_q  <= state_q == ST_ACKST && bad_q;
            busy_q <= state_d != ST_IDLE;
        end
    end

    mm_memory_array #(.DW(DATAWIDTH_BUS), .AW(MEM_ADDR_WIDTH)) u_mem (
        .clk_i   (MM_Access_CLOCK_50),
        .en_i    (state_q == ST_ACCESS),
        .we_i    (wr_q),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (rdata)
    );

    assign MM_Access_Data_OutBUS = dout_q;
    assign MM_Access_ACK         = ack_q;
    assign MM_Access_ERR         = err_q;
    assign MM_Access_Busy        = busy_q;
endmodule
